// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - two-player buzzer quiz round controller
module quiz_round_ctrl #(
  parameter int NUM_Q     = 10,
  parameter int WIN_SCORE = 5,
  parameter int BEEP_CYC  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic [7:0] hex_joy,
  input  logic [2:0] q_ans,
  output logic [3:0] q_index,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic       lock_p1,
  output logic       lock_p2,
  output logic       beep,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int            CW        = (BEEP_CYC < 2) ? 1 : $clog2(BEEP_CYC + 1);
  localparam logic [3:0]    LAST_Q    = 4'(NUM_Q - 1);
  localparam logic [2:0]    WIN       = 3'(WIN_SCORE);
  localparam logic [CW-1:0] BEEP_LOAD = CW'(BEEP_CYC);

  typedef enum logic [2:0] {
    S_RELEASE = 3'd0,
    S_ARMED   = 3'd1,
    S_JUDGE   = 3'd2,
    S_ADVANCE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_sync1;
  logic [7:0]      r_sync2;
  logic [3:0]      r_q;
  logic [2:0]      r_s1;
  logic [2:0]      r_s2;
  logic            r_lk1;
  logic            r_lk2;
  logic            r_prio;
  logic            r_sel_p;
  logic [2:0]      r_sel_ch;
  logic [CW-1:0]   r_beep_cnt;

  logic [3:0]      w_n1;
  logic [3:0]      w_n2;
  logic            w_v1;
  logic            w_v2;
  logic            w_any_valid;
  logic            w_pick_p2;
  logic [2:0]      w_ch1;
  logic [2:0]      w_ch2;
  logic [2:0]      w_sel_score;
  logic [2:0]      w_score_inc;
  logic            w_correct;
  logic            w_other_locked;

  // Buttons are active-low; invert so a set bit means pressed (bit 3 = choice 1).
  assign w_n1 = ~r_sync2[7:4];
  assign w_n2 = ~r_sync2[3:0];

  // A press counts only when exactly one button of an unlocked player is down.
  assign w_v1 = (w_n1 != 4'd0) && ((w_n1 & (w_n1 - 4'd1)) == 4'd0) && !r_lk1;
  assign w_v2 = (w_n2 != 4'd0) && ((w_n2 & (w_n2 - 4'd1)) == 4'd0) && !r_lk2;
  assign w_any_valid = w_v1 || w_v2;
  assign w_pick_p2   = (w_v1 && w_v2) ? r_prio : w_v2;

  assign w_sel_score    = r_sel_p ? r_s2 : r_s1;
  assign w_score_inc    = (w_sel_score >= WIN) ? w_sel_score : w_sel_score + 3'd1;
  assign w_correct      = (r_sel_ch == q_ans);
  assign w_other_locked = r_sel_p ? r_lk1 : r_lk2;

  // Decode the pressed button of each player into a choice number 1..4.
  always_comb begin
    w_ch1 = 3'd4;
    if (w_n1[3])      w_ch1 = 3'd1;
    else if (w_n1[2]) w_ch1 = 3'd2;
    else if (w_n1[1]) w_ch1 = 3'd3;
    w_ch2 = 3'd4;
    if (w_n2[3])      w_ch2 = 3'd1;
    else if (w_n2[2]) w_ch2 = 3'd2;
    else if (w_n2[1]) w_ch2 = 3'd3;
  end

  // Two-flop synchronizer for the raw button lines; idle level is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= hex_joy;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RELEASE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; new_game overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RELEASE: if (r_sync2 == 8'hFF) w_state_nxt = S_ARMED;
      S_ARMED:   if (w_any_valid)      w_state_nxt = S_JUDGE;
      S_JUDGE: begin
        if (w_correct) w_state_nxt = (w_score_inc == WIN) ? S_DONE : S_ADVANCE;
        else           w_state_nxt = w_other_locked ? S_ADVANCE : S_RELEASE;
      end
      S_ADVANCE: w_state_nxt = (r_q == LAST_Q) ? S_DONE : S_RELEASE;
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_RELEASE;
    endcase
    if (new_game) w_state_nxt = S_RELEASE;
  end

  // Game datapath: selection, scores, locks, question index, priority, beep timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= 4'd0;
      r_s1       <= 3'd0;
      r_s2       <= 3'd0;
      r_lk1      <= 1'b0;
      r_lk2      <= 1'b0;
      r_prio     <= 1'b0;
      r_sel_p    <= 1'b0;
      r_sel_ch   <= 3'd0;
      r_beep_cnt <= '0;
    end else if (new_game) begin
      r_q        <= 4'd0;
      r_s1       <= 3'd0;
      r_s2       <= 3'd0;
      r_lk1      <= 1'b0;
      r_lk2      <= 1'b0;
      r_prio     <= 1'b0;
      r_beep_cnt <= '0;
    end else begin
      if (r_beep_cnt != '0) r_beep_cnt <= r_beep_cnt - 1'b1;
      case (r_state)
        S_ARMED: begin
          if (w_any_valid) begin
            r_sel_p  <= w_pick_p2;
            r_sel_ch <= w_pick_p2 ? w_ch2 : w_ch1;
            if (w_v1 && w_v2) r_prio <= ~r_prio;
          end
        end
        S_JUDGE: begin
          if (w_correct) begin
            if (r_sel_p) r_s2 <= w_score_inc;
            else         r_s1 <= w_score_inc;
            r_beep_cnt <= BEEP_LOAD;
          end else begin
            if (r_sel_p) r_lk2 <= 1'b1;
            else         r_lk1 <= 1'b1;
          end
        end
        S_ADVANCE: begin
          r_lk1 <= 1'b0;
          r_lk2 <= 1'b0;
          if (r_q != LAST_Q) r_q <= r_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Output mapping; game_over, winner and beep follow state so reset clears them at once.
  assign q_index   = r_q;
  assign score_p1  = r_s1;
  assign score_p2  = r_s2;
  assign lock_p1   = r_lk1;
  assign lock_p2   = r_lk2;
  assign state     = r_state;
  assign game_over = (r_state == S_DONE);
  assign beep      = (r_beep_cnt != '0) || (r_state == S_DONE);
  assign winner    = (r_state != S_DONE) ? 2'b00 :
                     (r_s1 > r_s2)       ? 2'b01 :
                     (r_s2 > r_s1)       ? 2'b10 : 2'b11;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - randomized self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;

  localparam int NQ   = 10;
  localparam int WS   = 5;
  localparam int BEEP = 4;
  localparam int ST_RELEASE = 0;
  localparam int ST_ARMED   = 1;
  localparam int ST_DONE    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_game;
  logic [7:0] hex_joy;
  logic [2:0] q_ans;
  logic [3:0] q_index;
  logic [2:0] score_p1, score_p2;
  logic       lock_p1, lock_p2;
  logic       beep, game_over;
  logic [1:0] winner;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  int ans [NQ];
  int m_s [2];
  bit m_lk [2];
  int m_q;
  bit m_prio;
  bit m_done;

  quiz_round_ctrl #(.NUM_Q(NQ), .WIN_SCORE(WS), .BEEP_CYC(BEEP)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .hex_joy(hex_joy), .q_ans(q_ans),
    .q_index(q_index), .score_p1(score_p1), .score_p2(score_p2),
    .lock_p1(lock_p1), .lock_p2(lock_p2), .beep(beep), .game_over(game_over),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  // Question table lookup.
  always_comb begin
    q_ans = 3'd0;
    if (int'(q_index) < NQ) q_ans = 3'(ans[q_index]);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] p1(input int c);
    logic [7:0] v;
    v = 8'hFF;
    v[8 - c] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] p2(input int c);
    logic [7:0] v;
    v = 8'hFF;
    v[4 - c] = 1'b0;
    return v;
  endfunction

  function automatic int wrong(input int c);
    return (c % 4) + 1;
  endfunction

  function automatic int choice_of(input logic [3:0] nib);
    for (int k = 1; k <= 4; k++) if (nib[4 - k] == 1'b0) return k;
    return 0;
  endfunction

  function automatic bit single(input logic [3:0] nib);
    logic [3:0] pressed;
    pressed = ~nib;
    return $countones(pressed) == 1;
  endfunction

  task automatic model_reset();
    m_s[0] = 0; m_s[1] = 0; m_lk[0] = 0; m_lk[1] = 0;
    m_q = 0; m_prio = 0; m_done = 0;
  endtask

  task automatic model_advance();
    m_lk[0] = 0; m_lk[1] = 0;
    if (m_q == NQ - 1) m_done = 1;
    else m_q++;
  endtask

  task automatic model_press(input logic [7:0] p, output bit scored, output bit taken);
    bit v1, v2;
    int pl, ch;
    scored = 0;
    taken  = 0;
    if (m_done) return;
    v1 = single(p[7:4]) && !m_lk[0];
    v2 = single(p[3:0]) && !m_lk[1];
    if (!v1 && !v2) return;
    taken = 1;
    if (v1 && v2) begin
      pl = int'(m_prio);
      m_prio = !m_prio;
    end else begin
      pl = v2 ? 1 : 0;
    end
    ch = choice_of(pl == 0 ? p[7:4] : p[3:0]);
    if (ch == ans[m_q]) begin
      scored = 1;
      if (m_s[pl] < WS) m_s[pl]++;
      if (m_s[pl] == WS) m_done = 1;
      else model_advance();
    end else begin
      m_lk[pl] = 1;
      if (m_lk[0] && m_lk[1]) model_advance();
    end
  endtask

  function automatic int exp_winner();
    if (!m_done) return 0;
    if (m_s[0] > m_s[1]) return 1;
    if (m_s[1] > m_s[0]) return 2;
    return 3;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".s1"}, int'(score_p1), m_s[0]);
    check({tag, ".s2"}, int'(score_p2), m_s[1]);
    check({tag, ".lk1"}, int'(lock_p1), int'(m_lk[0]));
    check({tag, ".lk2"}, int'(lock_p2), int'(m_lk[1]));
    check({tag, ".q"}, int'(q_index), m_q);
    check({tag, ".over"}, int'(game_over), int'(m_done));
    check({tag, ".win"}, int'(winner), exp_winner());
  endtask

  // Hold a pattern, then release, counting beep cycles over the whole window.
  task automatic do_press(input string tag, input logic [7:0] p);
    bit scored, taken;
    int bc;
    model_press(p, scored, taken);
    bc = 0;
    hex_joy = p;
    repeat (10) begin
      @(negedge clk);
      if (beep) bc++;
    end
    check({tag, ".st"}, int'(state), m_done ? ST_DONE : (taken ? ST_RELEASE : ST_ARMED));
    hex_joy = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      if (beep) bc++;
    end
    check_all(tag);
    if (m_done) check({tag, ".beep_on"}, int'(beep), 1);
    else        check({tag, ".beep_len"}, bc, scored ? BEEP : 0);
  endtask

  task automatic do_new_game(input string tag);
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_reset();
    check({tag, ".st"}, int'(state), ST_RELEASE);
    check({tag, ".beep"}, int'(beep), 0);
    check_all(tag);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".st"}, int'(state), ST_RELEASE);
    check({tag, ".beep"}, int'(beep), 0);
    check_all(tag);
    hex_joy = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] pat;
  int sel, pc, cc;
  bit seen;

  initial begin
    rst_n = 1'b0;
    new_game = 1'b0;
    hex_joy = 8'hFF;
    for (int i = 0; i < NQ; i++) ans[i] = $urandom_range(1, 4);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.st", int'(state), ST_RELEASE);
    check("rst.beep", int'(beep), 0);
    check_all("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Correct press, wrong-then-right, both wrong, priority ties.
    do_press("c1", p1(ans[0]));
    do_press("w2", p2(wrong(ans[1])));
    do_press("r2", p1(ans[1]));
    do_press("bw1", p1(wrong(ans[2])));
    do_press("lockd", p1(ans[2]));
    do_press("bw2", p2(wrong(ans[2])));
    do_press("multi", 8'h3F & p2(ans[3]) | 8'h0F);
    do_press("tie1", p1(ans[3]) & p2(ans[3]));
    do_press("tie2", p1(ans[4]) & p2(ans[4]));
    for (int i = 0; i < 4; i++) do_press("p2win", p2(ans[m_q]));
    do_press("ignored", p1(ans[m_q]));
    do_new_game("ng1");

    // Run out of questions at 2-2.
    do_press("x0", p1(ans[0]));
    do_press("x1", p1(ans[1]));
    do_press("x2", p2(ans[2]));
    do_press("x3", p2(ans[3]));
    for (int q = 4; q < NQ; q++) begin
      do_press("xw1", p1(wrong(ans[q])));
      do_press("xw2", p2(wrong(ans[q])));
    end
    do_reset("rst_done");

    // Reset while the beep timer is running.
    hex_joy = p2(ans[0]);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (beep) seen = 1;
    end
    check("beep_seen", int'(seen), 1);
    @(negedge clk);
    do_reset("rst_beep");

    // Randomized games.
    for (int n = 0; n < 250; n++) begin
      if (m_done || $urandom_range(0, 29) == 0) do_new_game("rng");
      sel = $urandom_range(0, 9);
      pc = $urandom_range(1, 4);
      cc = $urandom_range(1, 4);
      case (sel)
        0, 1, 2: pat = p1(pc);
        3, 4, 5: pat = p2(pc);
        6, 7:    pat = p1(pc) & p2(cc);
        8:       pat = 8'($urandom);
        default: pat = ($urandom_range(0, 1) == 1) ? p2(ans[m_q]) : p1(ans[m_q]);
      endcase
      do_press("rnd", pat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 Parameter NUM_Q, default 10, number of questions per game (q_index range 0..NUM_Q-1).
REQ-002 Parameter WIN_SCORE, default 5, score that ends the game immediately.
REQ-003 Parameter BEEP_CYC, default 50_000_000, length of correct-answer beep in clk cycles.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 new_game  in  1  synchronous one-cycle pulse that restarts the game from DONE or any state.
REQ-007 hex_joy  in  8  raw active-low buttons: bits 7..4 = P1 choice 1..4, bits 3..0 = P2 choice 1..4.
REQ-008 q_ans  in  3  correct choice (1..4) for the current q_index, supplied combinationally by the question table.
REQ-009 q_index  out  4  current question number.
REQ-010 score_p1, score_p2  out  3 each  player scores, 0..WIN_SCORE.
REQ-011 lock_p1, lock_p2  out  1 each  player is locked out for the current question.
REQ-012 beep  out  1  buzzer drive, active-high.
REQ-013 game_over  out  1  high while in DONE.
REQ-014 winner  out  2  valid in DONE: 01 = P1, 10 = P2, 11 = draw; 00 otherwise.
REQ-015 state  out  3  FSM state encoding, for debug.

Function
REQ-016 hex_joy SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (sj).
REQ-017 A player's press is valid only when exactly one of that player's 4 bits in sj is low and the player is not locked; multi-bit presses are ignored.
REQ-018 FSM states: RELEASE, ARMED, JUDGE, ADVANCE, DONE.
REQ-019 RELEASE: wait until sj == 8'hFF, then enter ARMED on the next edge.
REQ-020 ARMED: on any valid press, register sel_player and sel_choice, then enter JUDGE on the next edge; with no valid press, stay in ARMED.
REQ-021 Simultaneous valid presses from both players: the winner is the player holding priority bit prio (reset 0 = P1); prio toggles after each such tie.
REQ-022 JUDGE, correct (sel_choice == q_ans): increment the selected score, load the beep counter with BEEP_CYC, and go to DONE if the new score == WIN_SCORE, else to ADVANCE.
REQ-023 JUDGE, wrong: set the selected player's lock; go to ADVANCE if both locks are now set, else to RELEASE.
REQ-024 ADVANCE: clear both locks; go to DONE if q_index == NUM_Q-1 (q_index is held), else increment q_index and go to RELEASE.
REQ-025 Score output visible exactly one cycle after JUDGE; no press is accepted until all buttons are released.
REQ-026 beep is high while the beep counter is nonzero; the counter decrements each cycle; beep is held high continuously in DONE.
REQ-027 DONE: game_over = 1; winner computed from the scores (greater score wins, equal = 11); all presses ignored.
REQ-028 new_game (any state): next edge clears scores, locks, q_index, beep counter and prio, and enters RELEASE; new_game wins over every other transition in the same cycle.
REQ-029 Scores saturate at WIN_SCORE; q_index never exceeds NUM_Q-1.

Reset
REQ-030 rst_n low SHALL immediately force: state = RELEASE, q_index = 0, scores = 0, locks = 0, beep = 0, game_over = 0, winner = 00, prio = 0, synchronizer flops = 1.
REQ-031 Reset asserted mid-JUDGE or mid-beep discards the pending score or beep; there is no partial update after release.

Verification (bench: BEEP_CYC = 4, NUM_Q = 10, WIN_SCORE = 5)
REQ-032 Correct press: q_ans = 3, sj = 8'hDF (P1 choice 3) -> score_p1 0 -> 1, beep high 4 cycles, q_index 0 -> 1, state RELEASE until 8'hFF.
REQ-033 Wrong then right: q_ans = 2, P2 presses 1 (8'hF7) -> lock_p2 = 1, q_index unchanged; release, then P1 presses 2 (8'hBF) -> score_p1 +1, locks cleared, q_index +1.
REQ-034 Both wrong: q_ans = 4, P1 presses 1, release, P2 presses 1 -> scores unchanged, q_index +1, both locks 0.
REQ-035 Tie: sj = 8'h77 (both choice 1), q_ans = 1 -> P1 scores; repeat on the next question -> P2 scores (prio toggled).
REQ-036 Win and end: P2 reaches 5 -> game_over = 1, winner = 10, beep steady, presses ignored; new_game pulse -> everything returns to 0, state RELEASE.
REQ-037 Questions exhausted at 2-2 -> DONE with winner = 11; asserting rst_n = 0 mid-beep -> beep = 0 immediately.
